// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite drawers
package sprite_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  coord_t;

    localparam int   SCREEN_W        = 640;
    localparam int   SCREEN_H        = 480;
    localparam rgb_t TRANSPARENT_KEY = 24'hFF00FF;

    // Bits needed to index every pixel of a w x h sprite.
    function automatic int sprite_addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/sprite_box_addr.sv
// rtl/sprite_box_addr.sv - combinational in-box test and sprite RAM address
// Shared by the monster, doodler and platform drawers.
module sprite_box_addr
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16
) (
    input  logic       en,
    input  coord_t     draw_x,
    input  coord_t     draw_y,
    input  coord_t     pos_x,
    input  coord_t     pos_y,
    output logic       in_box,
    output logic [8:0] addr
);

    logic [10:0] dx11;
    logic [10:0] dy11;

    // Sums carried in 11 bits so a sprite near X/Y = 1023 never wraps to 0.
    always_comb begin
        dx11   = {1'b0, draw_x} - {1'b0, pos_x};
        dy11   = {1'b0, draw_y} - {1'b0, pos_y};
        in_box = en
               & ({1'b0, draw_x} >= {1'b0, pos_x})
               & ({1'b0, draw_x} <  ({1'b0, pos_x} + 11'(SPRITE_W)))
               & ({1'b0, draw_y} >= {1'b0, pos_y})
               & ({1'b0, draw_y} <  ({1'b0, pos_y} + 11'(SPRITE_H)));
        addr   = in_box ? 9'(dy11 * 11'(SPRITE_W) + dx11) : 9'd0;
    end

endmodule

// File: rtl/monster_sprite_drawer.sv
// rtl/monster_sprite_drawer.sv - monster sprite pixel stage with frame latch and hit flash
// Three-cycle pipeline: address, RAM read, colour-keyed output.
module monster_sprite_drawer
    import sprite_pkg::*;
#(
    parameter int         SPRITE_W     = 16,
    parameter int         SPRITE_H     = 16,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_KEY,
    parameter logic [5:0] FLASH_FRAMES = 6'd32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  MonsterX,
    input  logic [9:0]  MonsterY,
    input  logic        monster_on,
    input  logic        hit_pulse,
    output logic [8:0]  ram_read_address,
    input  logic [23:0] ram_data,
    output logic        pixel_valid,
    output logic [23:0] pixel_rgb
);

    logic       frame_clk_q;
    coord_t     pos_x_q, pos_x_d;
    coord_t     pos_y_q, pos_y_d;
    logic       on_q, on_d;
    logic [5:0] flash_cnt_q, flash_cnt_d;
    logic [8:0] addr_q, addr_d;
    logic       in_box1_q, in_box1_d;
    logic       in_box2_q, in_box2_d;
    logic       valid_q, valid_d;
    rgb_t       rgb_q, rgb_d;

    logic       frame_edge;
    logic       flash_on;
    logic       in_box;
    logic [8:0] box_addr;

    sprite_box_addr #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_box (
        .en     (on_q),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .pos_x  (pos_x_q),
        .pos_y  (pos_y_q),
        .in_box (in_box),
        .addr   (box_addr)
    );

    always_comb begin
        frame_edge  = frame_clk & ~frame_clk_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        on_d        = on_q;
        flash_cnt_d = flash_cnt_q;
        if (frame_edge) begin
            pos_x_d = MonsterX;
            pos_y_d = MonsterY;
            on_d    = monster_on;
            if (flash_cnt_q != 6'd0) begin
                flash_cnt_d = flash_cnt_q - 6'd1;
            end
        end
        // A new hit restarts the flash and beats a same-cycle decrement.
        if (hit_pulse) begin
            flash_cnt_d = FLASH_FRAMES;
        end

        addr_d    = box_addr;
        in_box1_d = in_box;
        in_box2_d = in_box1_q;

        flash_on = (flash_cnt_q != 6'd0) & flash_cnt_q[2];
        valid_d  = in_box2_q & (ram_data != TRANSPARENT);
        rgb_d    = valid_d ? (flash_on ? ~ram_data : ram_data) : 24'd0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            on_q        <= 1'b0;
            flash_cnt_q <= '0;
            addr_q      <= '0;
            in_box1_q   <= 1'b0;
            in_box2_q   <= 1'b0;
            valid_q     <= 1'b0;
            rgb_q       <= '0;
        end else begin
            frame_clk_q <= frame_clk;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            on_q        <= on_d;
            flash_cnt_q <= flash_cnt_d;
            addr_q      <= addr_d;
            in_box1_q   <= in_box1_d;
            in_box2_q   <= in_box2_d;
            valid_q     <= valid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign ram_read_address = addr_q;
    assign pixel_valid      = valid_q;
    assign pixel_rgb        = rgb_q;

endmodule

// File: tb/tb_monster_sprite_drawer.sv
// tb/tb_monster_sprite_drawer.sv - directed self-checking bench for monster_sprite_drawer
module tb_monster_sprite_drawer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  MonsterX = '0;
    logic [9:0]  MonsterY = '0;
    logic        monster_on = 1'b0;
    logic        hit_pulse = 1'b0;
    logic [8:0]  ram_read_address;
    logic [23:0] ram_data = '0;
    logic        pixel_valid;
    logic [23:0] pixel_rgb;

    int passed = 0;
    int total  = 0;

    monster_sprite_drawer dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .MonsterX         (MonsterX),
        .MonsterY         (MonsterY),
        .monster_on       (monster_on),
        .hit_pulse        (hit_pulse),
        .ram_read_address (ram_read_address),
        .ram_data         (ram_data),
        .pixel_valid      (pixel_valid),
        .pixel_rgb        (pixel_rgb)
    );

    always #5 Clk = ~Clk;

    // Sprite RAM model: address 0 holds the colour key, others a tagged address.
    function automatic logic [23:0] mem_f(input logic [8:0] a);
        if (a == 9'd0) return 24'hFF00FF;
        return {12'h00A, 3'b000, a};
    endfunction

    always_ff @(posedge Clk) ram_data <= mem_f(ram_read_address);

    task automatic frame_tick(input logic with_hit);
        @(negedge Clk);
        frame_clk = 1'b1;
        hit_pulse = with_hit;
        @(negedge Clk);
        frame_clk = 1'b0;
        hit_pulse = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic exp_v, input logic [23:0] exp_rgb);
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (pixel_valid !== exp_v || pixel_rgb !== exp_rgb)
            $display("FAIL %s: got valid=%0b rgb=%h, want valid=%0b rgb=%h",
                     name, pixel_valid, pixel_rgb, exp_v, exp_rgb);
        else passed++;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (pixel_valid !== 1'b0 || pixel_rgb !== 24'd0 || ram_read_address !== 9'd0)
            $display("FAIL reset_state: got v=%0b rgb=%h addr=%0d, want 0/0/0",
                     pixel_valid, pixel_rgb, ram_read_address);
        else passed++;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_basic;
        MonsterX = 10'd100; MonsterY = 10'd50; monster_on = 1'b1;
        frame_tick(1'b0);
        @(negedge Clk);
        DrawX = 10'd105; DrawY = 10'd53;
        @(posedge Clk); #1;
        total++;
        if (ram_read_address !== 9'd53)
            $display("FAIL addr_53: got %0d, want 53", ram_read_address);
        else passed++;
        pix("pix_105_53", 10'd105, 10'd53, 1'b1, 24'h00A035);
        pix("transparent", 10'd100, 10'd50, 1'b0, 24'd0);
        pix("right_past", 10'd116, 10'd53, 1'b0, 24'd0);
        pix("last_col", 10'd115, 10'd50, 1'b1, 24'h00A00F);
        pix("bottom_row", 10'd105, 10'd65, 1'b1, 24'h00A0F5);
        pix("bottom_past", 10'd105, 10'd66, 1'b0, 24'd0);
        pix("left_before", 10'd99, 10'd53, 1'b0, 24'd0);
    endtask

    task automatic test_reset_midframe;
        @(negedge Clk);
        DrawX = 10'd105; DrawY = 10'd53;
        repeat (3) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if (pixel_valid !== 1'b0 || pixel_rgb !== 24'd0 || ram_read_address !== 9'd0)
            $display("FAIL reset_async: got v=%0b rgb=%h addr=%0d, want 0/0/0",
                     pixel_valid, pixel_rgb, ram_read_address);
        else passed++;
        @(negedge Clk);
        Reset = 1'b0;
        pix("no_draw_after_reset", 10'd105, 10'd53, 1'b0, 24'd0);
        frame_tick(1'b0);
        pix("draw_after_frame", 10'd105, 10'd53, 1'b1, 24'h00A035);
    endtask

    task automatic test_midframe_move;
        MonsterX = 10'd200;
        pix("move_old_pos", 10'd105, 10'd53, 1'b1, 24'h00A035);
        pix("move_new_not_yet", 10'd205, 10'd53, 1'b0, 24'd0);
        frame_tick(1'b0);
        pix("move_new_pos", 10'd205, 10'd53, 1'b1, 24'h00A035);
        pix("move_old_gone", 10'd105, 10'd53, 1'b0, 24'd0);
    endtask

    task automatic test_right_edge;
        MonsterX = 10'd1020;
        frame_tick(1'b0);
        pix("edge_1023", 10'd1023, 10'd53, 1'b1, 24'h00A033);
        pix("edge_1020", 10'd1020, 10'd53, 1'b1, 24'h00A030);
        pix("edge_nowrap_4", 10'd4, 10'd53, 1'b0, 24'd0);
        monster_on = 1'b0;
        frame_tick(1'b0);
        pix("monster_off", 10'd1023, 10'd53, 1'b0, 24'd0);
    endtask

    task automatic test_flash;
        int  cnt;
        logic inv;
        MonsterX = 10'd100; monster_on = 1'b1;
        frame_tick(1'b1);
        for (int k = 0; k <= 33; k++) begin
            cnt = (k >= 32) ? 0 : 32 - k;
            inv = (cnt >= 28 && cnt <= 31) || (cnt >= 20 && cnt <= 23) ||
                  (cnt >= 12 && cnt <= 15) || (cnt >= 4 && cnt <= 7);
            pix($sformatf("flash_cnt_%0d", cnt), 10'd105, 10'd53, 1'b1,
                inv ? 24'hFF5FCA : 24'h00A035);
            frame_tick(1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_reset_midframe;
        test_midframe_move;
        test_right_edge;
        test_flash;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/monster_sprite_drawer.md
Name: monster_sprite_drawer

Overview:
- Pixel-pipeline stage directly downstream of the monster sprite RAM.
- Turns the VGA raster position into a sprite RAM read address and takes the RAM's 24-bit colour word one cycle later.
- Emits a colour-keyed pixel (valid + RGB) for the colour mapper.
- Latches the monster position once per frame to avoid tearing, and runs a per-frame hit-flash effect.

Parameters:
- SPRITE_W, 16, sprite width in pixels (power of two).
- SPRITE_H, 16, sprite height in pixels; SPRITE_W*SPRITE_H <= 512.
- TRANSPARENT, 24'hFF00FF, colour key treated as "no pixel".
- FLASH_FRAMES, 6'd32, frames the hit flash lasts.

Ports:
- Clk  in  1  pixel/system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  vsync-derived frame strobe, synchronous to Clk; its rising edge marks a frame boundary.
- DrawX  in  10  current raster X.
- DrawY  in  10  current raster Y.
- MonsterX  in  10  sprite top-left X, unsigned.
- MonsterY  in  10  sprite top-left Y, unsigned.
- monster_on  in  1  monster alive/visible.
- hit_pulse  in  1  one-cycle strobe; starts the flash.
- ram_read_address  out  9  to the sprite RAM read_address.
- ram_data  in  24  from the sprite RAM data_Out (1-cycle read latency).
- pixel_valid  out  1  sprite covers this pixel.
- pixel_rgb  out  24  sprite colour; 0 when pixel_valid = 0.

Behaviour:
- Reset (async): every register and output is cleared.
  - ram_read_address = 0, pixel_valid = 0, pixel_rgb = 0.
  - Latched position = 0, latched on = 0, flash_cnt = 0, frame_clk_d = 0.
  - Nothing is drawn until the first frame edge after Reset deasserts, including when reset lands mid-frame.
- Frame edge: frame_edge = frame_clk & ~frame_clk_d (frame_clk_d is registered).
  - On frame_edge, latch MonsterX/MonsterY/monster_on into posX/posY/on_l.
  - On frame_edge, if flash_cnt != 0, decrement it; it saturates at 0.
- hit_pulse loads flash_cnt = FLASH_FRAMES, including while a flash is already running.
  - If hit_pulse and frame_edge coincide, the load wins over the decrement.
- Stage 1 (cycle t+1 after DrawX/DrawY are presented):
  - in_box = on_l & (DrawX >= posX) & (DrawX < posX+SPRITE_W) & (DrawY >= posY) & (DrawY < posY+SPRITE_H).
  - Do all sums in 11 bits so positions near 1023 do not wrap.
  - ram_read_address <= (DrawY-posY)*SPRITE_W + (DrawX-posX), truncated to 9 bits, registered.
  - When in_box = 0, ram_read_address is don't-care; it holds 0.
  - Register in_box1 <= in_box.
- Stage 2 (t+2): the RAM presents ram_data; register in_box2 <= in_box1.
- Stage 3 (t+3), registered outputs:
  - pixel_valid <= in_box2 & (ram_data != TRANSPARENT).
  - pixel_rgb <= pixel_valid_next ? (flash_on ? ~ram_data : ram_data) : 0.
  - flash_on = (flash_cnt != 0) & flash_cnt[2], i.e. alternates every 4 frames.
- Total latency from DrawX/DrawY to pixel output is exactly 3 Clk cycles, with throughput 1 pixel/cycle and no stalls. The consumer delays DrawX/DrawY by 3 to match.
- The position latch updates only on frame_edge, so mid-frame changes to MonsterX/MonsterY have no visible effect.
- Sprite partly off the right or bottom edge: the visible part draws normally, with no wrap to the left edge.
- The block never writes to the RAM; the RAM's write enable is tied off elsewhere.

Decomposition:
- Shared package sprite_pkg:
  - typedef rgb_t (logic [23:0]), typedef coord_t (logic [9:0]).
  - Constants SCREEN_W = 640, SCREEN_H = 480, TRANSPARENT_KEY.
  - Localparam function for the sprite address width.
- One natural sub-module: sprite_box_addr, the combinational in-box test plus address compute. It is reused for the doodler and platform drawers.
- The frame-edge detector, flash counter and pipeline registers stay in the top module.

Test Plan:
- Reset asserted mid-frame with the monster on screen → all outputs 0 on the same cycle. After release, pixel_valid stays 0 until the first frame_clk rise plus 3 cycles into the raster.
- Latch MonsterX = 100, MonsterY = 50; raster DrawX = 105, DrawY = 53 with a RAM model returning mem[addr] → ram_read_address = 53 one cycle later. pixel_rgb = mem[53] appears 3 cycles after the input, with pixel_valid = 1.
- RAM word = 24'hFF00FF inside the box → pixel_valid = 0, pixel_rgb = 0. DrawX = 116 (first column past the sprite) → pixel_valid = 0.
- MonsterX changed to 200 mid-frame → output still follows posX = 100 until the next frame_clk rise, then follows 200.
- MonsterX = 1020, DrawX = 1023 / 1020 / 4 → in box for 1023 and 1020; DrawX = 4 is never valid (no 10-bit wrap).
- hit_pulse on the same cycle as frame_edge → flash_cnt = 32. After frame edges:
  - Colour is inverted (~rgb) while flash_cnt is 31..28, 23..20, 15..12 and 7..4.
  - Colour is normal otherwise, and after 32 frame edges flash_cnt = 0.
